ula_arbiter: RTL and testbench
==============================

# ula_arbiter

Sequencing and arbitration front-end for the shared 16-bit ULA. It accepts operation requests from two requesters (e.g. the execute stage and a branch/compare unit) over valid/ready handshakes and grants them round-robin. It drives the combinational ULA from registered operands, captures `Res` and `FlagReg` one cycle later, and returns them on a single tagged response channel. Only one operation is in flight at any time.

## Interface
Parameters:
- `W`, 16, operand/result width; must match the ULA.
- `CW`, 4, opcode width; must match `CodeULA`.

Ports:
- `CLK` in 1: the only clock; all state changes on its rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `ReqVal0`, `ReqVal1` in 1: request valid, requester 0 / 1.
- `ReqRdy0`, `ReqRdy1` out 1: request accepted this cycle (combinational).
- `ReqCode0`, `ReqCode1` in CW: opcode (ADD=0 … BEZ=6).
- `ReqOpA0`, `ReqOpA1`, `ReqOpB0`, `ReqOpB1` in W: operands.
- `AluCode` out CW: registered opcode to the ULA `CodeULA`.
- `AluOpA`, `AluOpB` out W: registered operands to the ULA.
- `AluRes` in W: ULA `Res`.
- `AluFlags` in 3: ULA `FlagReg` [Z N V].
- `RspVal` out 1: response valid.
- `RspRdy` in 1: response consumer ready.
- `RspId` out 1: requester that owns the response.
- `RspRes` out W: captured result.
- `RspFlags` out 3: captured [Z N V].
- `RspErr` out 1: opcode was greater than 6 (unsupported).

## Operation
- FSM states:
  - IDLE: no operation; may accept.
  - EXEC: ULA driven from registers; result settling.
  - RESP: response held.
- Accept condition `acc = (state==IDLE) | (state==RESP & RspRdy)`.
- Grant:
  - If only one `ReqVal` is high, that requester wins.
  - If both are high, requester `Ptr` wins.
  - `ReqRdyi = acc & grant_i & RST`; at most one `ReqRdy` is high per cycle.
- On accept:
  - Latch code and operands into `AluCode/AluOpA/AluOpB`.
  - Latch winner index into an internal id register.
  - Set `Ptr <= ~winner`, so the loser gets priority next time.
  - Go to EXEC.
- Pointer moves only on an actual grant; an idle cycle or a single requester does not disturb fairness beyond that rule.
- EXEC (exactly one cycle), then RESP:
  - `RspRes <= AluRes`.
  - `RspFlags <= AluFlags`, except when `AluCode==6` (BEZ): bits N and V are forced to 0, Z is taken from the ULA.
  - `RspErr <= (AluCode > 6)`; the ULA result (0) and flags (0) are still returned.
  - `RspId <= id`; `RspVal <= 1`.
- RESP:
  - `RspVal` stays high and all `Rsp*` outputs stay stable until `RspRdy`.
  - On `RspRdy` with a new accept: go directly to EXEC (back-to-back).
  - On `RspRdy` without a new accept: clear `RspVal` and go to IDLE.
- Requesters must hold code and operands stable while `ReqVal` is high and `ReqRdy` is low. Dropping `ReqVal` before a grant is allowed; nothing is recorded.
- `AluCode/AluOpA/AluOpB` hold their last values in IDLE and RESP.

## Timing
- Reset (RST low, asynchronous):
  - state=IDLE, `Ptr`=0.
  - `RspVal`=0, `RspId`=0, `RspRes`=0, `RspFlags`=0, `RspErr`=0.
  - `AluCode`=0, `AluOpA`=0, `AluOpB`=0.
  - `ReqRdy0`=`ReqRdy1`=0 while RST is low.
- Reset mid-operation: the in-flight operation and any pending response are discarded silently. Nothing is replayed after release.
- Latency: accept edge at cycle t → ULA inputs valid during t+1 → `RspVal` high from t+2.
- Throughput:
  - With `RspRdy` held high: one operation every 2 cycles.
  - Otherwise: limited by the response consumer.
- No request is accepted during EXEC; `ReqRdy` is 0 there regardless of `ReqVal`.
- Simultaneous `RspRdy` and new grant in RESP: the old response retires and the new operation enters EXEC on the same edge. `RspVal` drops for exactly one cycle (the EXEC cycle).
- Arithmetic, overflow and flag semantics are entirely the ULA's. The arbiter performs no width conversion; all buses are W bits wide.

## Test plan
- **Reset and single ADD.**
  - Stimulus: RST low → all outputs at the reset values above. Release, then `ReqVal0`=1, code 0, A=0x0003, B=0x0004.
  - Required: `ReqRdy0`=1 in the first cycle; `RspVal`=1 two cycles later with `RspRes`=0x0007, `RspFlags`=000, `RspId`=0.
- **Round-robin.**
  - Stimulus: both requesters hold valid continuously with SUB 0x0005−0x0005; `RspRdy`=1.
  - Required: grants alternate 0,1,0,1 on every accept cycle; each response has `RspRes`=0, `RspFlags`=100, and `RspId` alternates.
- **Backpressure.**
  - Stimulus: `RspRdy`=0 for 5 cycles after the response appears, then 1.
  - Required: `RspVal`, `RspRes` and `RspId` stay stable; `ReqRdy` stays 0; a pending request is accepted only in the cycle `RspRdy`=1.
- **Overflow and BEZ.**
  - Stimulus: ADD 0x7FFF+0x0001, then BEZ with A=0, B=0x1234.
  - Required: first response `RspRes`=0x8000, `RspFlags`=011. Second response `RspRes`=0x1234, `RspFlags`=100 (N and V forced 0, no X).
- **Illegal opcode.**
  - Stimulus: code 0xF.
  - Required: `RspErr`=1, `RspRes`=0, `RspFlags`=000; the next legal request gives `RspErr`=0.
- **Reset mid-op.**
  - Stimulus: assert RST during EXEC.
  - Required: `RspVal`=0 immediately (asynchronous); after release, `Ptr`=0, so with both requesters valid requester 0 is granted first.

Source files
------------

// File: rtl/ula_arbiter_if.sv
// ----------------------------------------------------------------------------
// ula_arbiter_if
// Bundle of every handshake / bus signal around the ULA arbiter.
//   Request side : ReqVal0/1, ReqRdy0/1, ReqCode0/1, ReqOpA0/1, ReqOpB0/1
//   ULA side     : AluCode, AluOpA, AluOpB (to ULA), AluRes, AluFlags (from ULA)
//   Response side: RspVal, RspRdy, RspId, RspRes, RspFlags, RspErr
// Modports:
//   slave  - the arbiter itself
//   master - the environment (requesters, ULA and response consumer)
// ----------------------------------------------------------------------------
interface ula_arbiter_if #(
  parameter int W  = 16,
  parameter int CW = 4
);
  logic          ReqVal0;
  logic          ReqVal1;
  logic          ReqRdy0;
  logic          ReqRdy1;
  logic [CW-1:0] ReqCode0;
  logic [CW-1:0] ReqCode1;
  logic [W-1:0]  ReqOpA0;
  logic [W-1:0]  ReqOpA1;
  logic [W-1:0]  ReqOpB0;
  logic [W-1:0]  ReqOpB1;

  logic [CW-1:0] AluCode;
  logic [W-1:0]  AluOpA;
  logic [W-1:0]  AluOpB;
  logic [W-1:0]  AluRes;
  logic [2:0]    AluFlags;

  logic          RspVal;
  logic          RspRdy;
  logic          RspId;
  logic [W-1:0]  RspRes;
  logic [2:0]    RspFlags;
  logic          RspErr;

  modport slave (
    input  ReqVal0, ReqVal1, ReqCode0, ReqCode1,
    input  ReqOpA0, ReqOpA1, ReqOpB0, ReqOpB1,
    output ReqRdy0, ReqRdy1,
    output AluCode, AluOpA, AluOpB,
    input  AluRes, AluFlags,
    output RspVal, RspId, RspRes, RspFlags, RspErr,
    input  RspRdy
  );

  modport master (
    output ReqVal0, ReqVal1, ReqCode0, ReqCode1,
    output ReqOpA0, ReqOpA1, ReqOpB0, ReqOpB1,
    input  ReqRdy0, ReqRdy1,
    input  AluCode, AluOpA, AluOpB,
    output AluRes, AluFlags,
    input  RspVal, RspId, RspRes, RspFlags, RspErr,
    output RspRdy
  );
endinterface

// File: rtl/ula_arbiter.sv
// ----------------------------------------------------------------------------
// ula_arbiter
// Sequencing / arbitration front-end for the shared combinational ULA.
// Two requesters are granted round-robin over valid/ready handshakes; the
// winning opcode and operands are registered onto the ULA inputs, the ULA
// result and [Z N V] flags are captured one cycle later and presented on a
// single tagged response channel. At most one operation is in flight.
//
// Ports:
//   CLK  in  : clock, rising edge
//   RST  in  : asynchronous reset, active low
//   bus  slave modport of ula_arbiter_if:
//     ReqVal0/1, ReqCode0/1, ReqOpA0/1, ReqOpB0/1 in ; ReqRdy0/1 out (comb)
//     AluCode, AluOpA, AluOpB out (registered) ; AluRes, AluFlags in
//     RspVal, RspId, RspRes, RspFlags, RspErr out (registered) ; RspRdy in
// ----------------------------------------------------------------------------
module ula_arbiter #(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic            CLK,
  input  logic            RST,
  ula_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [CW-1:0] OP_BEZ = CW'(6);

  state_t        state_q;
  logic          ptr_q;
  logic          id_q;
  logic [CW-1:0] alu_code_q;
  logic [W-1:0]  alu_opa_q;
  logic [W-1:0]  alu_opb_q;
  logic          rsp_val_q;
  logic          rsp_id_q;
  logic [W-1:0]  rsp_res_q;
  logic [2:0]    rsp_flags_q;
  logic          rsp_err_q;

  logic          acc;
  logic          gnt0;
  logic          gnt1;
  logic          take;
  logic [CW-1:0] win_code;
  logic [W-1:0]  win_opa;
  logic [W-1:0]  win_opb;
  logic [2:0]    rsp_flags_d;
  logic          rsp_err_d;

  always_comb begin
    // A new operation may start from IDLE, or from RESP on the same edge
    // that the current response retires.
    acc  = (state_q == IDLE) | ((state_q == RESP) & bus.RspRdy);
    // Sole requester wins; on contention the pointer decides.
    gnt0 = bus.ReqVal0 & (~bus.ReqVal1 | ~ptr_q);
    gnt1 = bus.ReqVal1 & (~bus.ReqVal0 |  ptr_q);
    take = acc & (gnt0 | gnt1) & RST;

    win_code = gnt1 ? bus.ReqCode1 : bus.ReqCode0;
    win_opa  = gnt1 ? bus.ReqOpA1  : bus.ReqOpA0;
    win_opb  = gnt1 ? bus.ReqOpB1  : bus.ReqOpB0;

    // BEZ only defines Z; N and V from the ULA are meaningless there.
    rsp_err_d   = (alu_code_q > OP_BEZ);
    rsp_flags_d = (alu_code_q == OP_BEZ) ? {bus.AluFlags[2], 2'b00} : bus.AluFlags;
  end

  assign bus.ReqRdy0  = acc & gnt0 & RST;
  assign bus.ReqRdy1  = acc & gnt1 & RST;

  assign bus.AluCode  = alu_code_q;
  assign bus.AluOpA   = alu_opa_q;
  assign bus.AluOpB   = alu_opb_q;

  assign bus.RspVal   = rsp_val_q;
  assign bus.RspId    = rsp_id_q;
  assign bus.RspRes   = rsp_res_q;
  assign bus.RspFlags = rsp_flags_q;
  assign bus.RspErr   = rsp_err_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      alu_code_q  <= '0;
      alu_opa_q   <= '0;
      alu_opb_q   <= '0;
      rsp_val_q   <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_res_q   <= '0;
      rsp_flags_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // take already implies acc, so this fires only in IDLE or retiring RESP.
      if (take) begin
        alu_code_q <= win_code;
        alu_opa_q  <= win_opa;
        alu_opb_q  <= win_opb;
        id_q       <= gnt1;
        ptr_q      <= ~gnt1;
      end

      case (state_q)
        IDLE: begin
          if (take) begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_res_q   <= bus.AluRes;
          rsp_flags_q <= rsp_flags_d;
          rsp_err_q   <= rsp_err_d;
          rsp_id_q    <= id_q;
          rsp_val_q   <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (bus.RspRdy) begin
            // Back-to-back: RspVal drops for exactly the EXEC cycle.
            rsp_val_q <= 1'b0;
            state_q   <= take ? EXEC : IDLE;
          end
        end
        default: begin
          rsp_val_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  a_one_grant: assert property (@(posedge CLK) disable iff (!RST)
    !(bus.ReqRdy0 && bus.ReqRdy1));

  a_no_grant_in_exec: assert property (@(posedge CLK) disable iff (!RST)
    (state_q == EXEC) |-> !(bus.ReqRdy0 || bus.ReqRdy1));

endmodule

// File: tb/tb_ula_arbiter.sv
module tb_ula_arbiter;

  logic CLK = 1'b0;
  logic RST;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [15:0] res;
    logic [2:0]  flags;
  } rsp_t;

  always #5 CLK = ~CLK;

  ula_arbiter_if #(.W(16), .CW(4)) bus ();

  ula_arbiter #(.W(16), .CW(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Environment ULA: {Res, FlagReg[Z N V]}. BEZ deliberately reports N=V=1
  // so the arbiter's masking is visible.
  function automatic logic [18:0] ula_model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        z, n, v;
    r = 16'h0; v = 1'b0;
    case (c)
      4'd0: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      4'd1: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = ~a;
      4'd6: return {b, (a == 16'h0), 1'b1, 1'b1};
      default: return 19'h0;
    endcase
    z = (r == 16'h0);
    n = r[15];
    return {r, z, n, v};
  endfunction

  // What the arbiter must return for a request, from the response rules.
  function automatic rsp_t exp_rsp(input logic id, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [18:0] raw;
    rsp_t e;
    raw     = ula_model(c, a, b);
    e.id    = id;
    e.err   = (c > 4'd6);
    e.res   = raw[18:3];
    e.flags = (c == 4'd6) ? {raw[2], 2'b00} : raw[2:0];
    return e;
  endfunction

  always_comb begin
    {bus.AluRes, bus.AluFlags} = ula_model(bus.AluCode, bus.AluOpA, bus.AluOpB);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.ReqVal0 = 1'b0; bus.ReqVal1 = 1'b0;
    bus.ReqCode0 = 4'h0; bus.ReqCode1 = 4'h0;
    bus.ReqOpA0 = 16'h0; bus.ReqOpA1 = 16'h0;
    bus.ReqOpB0 = 16'h0; bus.ReqOpB1 = 16'h0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b0;
    idle_inputs();
    bus.RspRdy = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
  endtask

  // Issue one request from requester rq, wait (bounded) for its response,
  // capture it and retire it. to=1 if either wait ran out.
  task automatic do_single(input int rq, input logic [3:0] c, input logic [15:0] a, input logic [15:0] b,
                           output rsp_t r, output bit to);
    int n;
    to = 1'b0;
    @(negedge CLK);
    bus.RspRdy = 1'b0;
    if (rq == 0) begin bus.ReqVal0 = 1'b1; bus.ReqCode0 = c; bus.ReqOpA0 = a; bus.ReqOpB0 = b; end
    else         begin bus.ReqVal1 = 1'b1; bus.ReqCode1 = c; bus.ReqOpA1 = a; bus.ReqOpB1 = b; end
    #1;
    n = 0;
    while (!(rq == 0 ? bus.ReqRdy0 : bus.ReqRdy1) && n < 10) begin @(negedge CLK); #1; n++; end
    if (n >= 10) to = 1'b1;
    @(negedge CLK);
    bus.ReqVal0 = 1'b0; bus.ReqVal1 = 1'b0;
    #1;
    n = 0;
    while (!bus.RspVal && n < 10) begin @(negedge CLK); #1; n++; end
    if (n >= 10) to = 1'b1;
    r = {bus.RspId, bus.RspErr, bus.RspRes, bus.RspFlags};
    bus.RspRdy = 1'b1;
    @(negedge CLK);
    bus.RspRdy = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b0;
    idle_inputs();
    bus.RspRdy = 1'b0;
    bus.ReqVal0 = 1'b1; bus.ReqVal1 = 1'b1;
    @(negedge CLK); #1;
    n_checks++;
    if ({bus.RspVal, bus.RspId, bus.RspRes, bus.RspFlags, bus.RspErr} !== 22'h0) begin
      n_fail++; $display("FAIL reset_rsp: got %h expected 0", {bus.RspVal, bus.RspId, bus.RspRes, bus.RspFlags, bus.RspErr});
    end
    n_checks++;
    if ({bus.AluCode, bus.AluOpA, bus.AluOpB} !== 36'h0) begin
      n_fail++; $display("FAIL reset_alu: got %h expected 0", {bus.AluCode, bus.AluOpA, bus.AluOpB});
    end
    n_checks++;
    if ({bus.ReqRdy1, bus.ReqRdy0} !== 2'b00) begin
      n_fail++; $display("FAIL reset_rdy: got %b expected 00", {bus.ReqRdy1, bus.ReqRdy0});
    end
    idle_inputs();
    @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_single_add();
    @(negedge CLK);
    bus.RspRdy = 1'b0;
    bus.ReqVal0 = 1'b1; bus.ReqCode0 = 4'd0; bus.ReqOpA0 = 16'h0003; bus.ReqOpB0 = 16'h0004;
    #1;
    n_checks++;
    if ({bus.ReqRdy1, bus.ReqRdy0} !== 2'b01) begin
      n_fail++; $display("FAIL add_rdy: got %b expected 01", {bus.ReqRdy1, bus.ReqRdy0});
    end
    @(negedge CLK);
    bus.ReqVal0 = 1'b0;
    #1;
    n_checks++;
    if ({bus.RspVal, bus.AluCode, bus.AluOpA, bus.AluOpB} !== {1'b0, 4'd0, 16'h0003, 16'h0004}) begin
      n_fail++; $display("FAIL add_exec: got %h expected %h", {bus.RspVal, bus.AluCode, bus.AluOpA, bus.AluOpB},
                         {1'b0, 4'd0, 16'h0003, 16'h0004});
    end
    @(negedge CLK); #1;
    n_checks++;
    if ({bus.RspVal, bus.RspRes, bus.RspFlags, bus.RspId, bus.RspErr} !== {1'b1, 16'h0007, 3'b000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL add_rsp: got val=%b res=%h flags=%b id=%b err=%b expected 1 0007 000 0 0",
                         bus.RspVal, bus.RspRes, bus.RspFlags, bus.RspId, bus.RspErr);
    end
    bus.RspRdy = 1'b1;
    @(negedge CLK);
    bus.RspRdy = 1'b0;
    #1;
    n_checks++;
    if (bus.RspVal !== 1'b0) begin
      n_fail++; $display("FAIL add_retire: got RspVal=%b expected 0", bus.RspVal);
    end
  endtask

  task automatic test_round_robin();
    logic exp_g;
    logic g;
    logic idq[$];
    int   grants, rsps;
    logic [1:0] want;
    apply_reset();
    @(negedge CLK);
    bus.ReqVal0 = 1'b1; bus.ReqCode0 = 4'd1; bus.ReqOpA0 = 16'h0005; bus.ReqOpB0 = 16'h0005;
    bus.ReqVal1 = 1'b1; bus.ReqCode1 = 4'd1; bus.ReqOpA1 = 16'h0005; bus.ReqOpB1 = 16'h0005;
    bus.RspRdy = 1'b1;
    exp_g = 1'b0; grants = 0; rsps = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      want = (k % 2 == 1) ? 2'b00 : ((k == 0) ? 2'b01 : 2'b11);
      n_checks++;
      if ({bus.RspVal, bus.ReqRdy0 | bus.ReqRdy1} !== want) begin
        n_fail++; $display("FAIL rr_cadence: cycle %0d got val/rdy=%b expected %b", k, {bus.RspVal, bus.ReqRdy0 | bus.ReqRdy1}, want);
      end
      if (bus.RspVal) begin
        rsps++;
        n_checks++;
        if (idq.size() == 0) begin
          n_fail++; $display("FAIL rr_rsp: got unexpected response expected none");
        end else if ({bus.RspRes, bus.RspFlags, bus.RspId} !== {16'h0000, 3'b100, idq[0]}) begin
          n_fail++; $display("FAIL rr_rsp: got res=%h flags=%b id=%b expected 0000 100 %b", bus.RspRes, bus.RspFlags, bus.RspId, idq[0]);
        end
        if (idq.size() != 0) void'(idq.pop_front());
      end
      if (bus.ReqRdy0 | bus.ReqRdy1) begin
        g = bus.ReqRdy1;
        grants++;
        n_checks++;
        if (g !== exp_g) begin
          n_fail++; $display("FAIL rr_grant: got %b expected %b", g, exp_g);
        end
        exp_g = ~exp_g;
        idq.push_back(g);
      end
      @(negedge CLK);
    end
    n_checks++;
    if (grants != 4 || rsps != 3) begin
      n_fail++; $display("FAIL rr_counts: got grants=%0d rsps=%0d expected 4 3", grants, rsps);
    end
    idle_inputs();
    repeat (3) @(negedge CLK);
    bus.RspRdy = 1'b0;
  endtask

  task automatic test_backpressure();
    @(negedge CLK);
    bus.RspRdy = 1'b0;
    bus.ReqVal0 = 1'b1; bus.ReqCode0 = 4'd0; bus.ReqOpA0 = 16'h0001; bus.ReqOpB0 = 16'h0002;
    #1;
    n_checks++;
    if (bus.ReqRdy0 !== 1'b1) begin
      n_fail++; $display("FAIL bp_first_rdy: got %b expected 1", bus.ReqRdy0);
    end
    @(negedge CLK);
    bus.ReqVal0 = 1'b0;
    bus.ReqVal1 = 1'b1; bus.ReqCode1 = 4'd0; bus.ReqOpA1 = 16'h0010; bus.ReqOpB1 = 16'h0020;
    #1;
    n_checks++;
    if (bus.ReqRdy1 !== 1'b0) begin
      n_fail++; $display("FAIL bp_exec_rdy: got %b expected 0", bus.ReqRdy1);
    end
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK); #1;
      n_checks++;
      if ({bus.RspVal, bus.RspRes, bus.RspId, bus.ReqRdy1} !== {1'b1, 16'h0003, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold: cycle %0d got val=%b res=%h id=%b rdy1=%b expected 1 0003 0 0",
                           k, bus.RspVal, bus.RspRes, bus.RspId, bus.ReqRdy1);
      end
    end
    @(negedge CLK);
    bus.RspRdy = 1'b1;
    #1;
    n_checks++;
    if ({bus.RspVal, bus.ReqRdy1} !== 2'b11) begin
      n_fail++; $display("FAIL bp_release: got val/rdy1=%b expected 11", {bus.RspVal, bus.ReqRdy1});
    end
    @(negedge CLK);
    bus.RspRdy = 1'b0; bus.ReqVal1 = 1'b0;
    #1;
    n_checks++;
    if ({bus.RspVal, bus.AluOpA, bus.AluOpB} !== {1'b0, 16'h0010, 16'h0020}) begin
      n_fail++; $display("FAIL bp_b2b_exec: got %h expected %h", {bus.RspVal, bus.AluOpA, bus.AluOpB}, {1'b0, 16'h0010, 16'h0020});
    end
    @(negedge CLK); #1;
    n_checks++;
    if ({bus.RspVal, bus.RspRes, bus.RspId} !== {1'b1, 16'h0030, 1'b1}) begin
      n_fail++; $display("FAIL bp_second_rsp: got val=%b res=%h id=%b expected 1 0030 1", bus.RspVal, bus.RspRes, bus.RspId);
    end
    bus.RspRdy = 1'b1;
    @(negedge CLK);
    bus.RspRdy = 1'b0;
  endtask

  task automatic test_overflow_bez();
    rsp_t r;
    bit   to;
    do_single(0, 4'd0, 16'h7FFF, 16'h0001, r, to);
    n_checks++;
    if ({to, r} !== {1'b0, 1'b0, 1'b0, 16'h8000, 3'b011}) begin
      n_fail++; $display("FAIL ovf_add: got to=%b rsp=%h expected to=0 rsp=%h", to, r, {1'b0, 1'b0, 16'h8000, 3'b011});
    end
    do_single(1, 4'd6, 16'h0000, 16'h1234, r, to);
    n_checks++;
    if ({to, r} !== {1'b0, 1'b1, 1'b0, 16'h1234, 3'b100}) begin
      n_fail++; $display("FAIL bez_taken: got to=%b rsp=%h expected to=0 rsp=%h", to, r, {1'b1, 1'b0, 16'h1234, 3'b100});
    end
    do_single(0, 4'd6, 16'h0005, 16'h0055, r, to);
    n_checks++;
    if ({to, r} !== {1'b0, 1'b0, 1'b0, 16'h0055, 3'b000}) begin
      n_fail++; $display("FAIL bez_not_taken: got to=%b rsp=%h expected to=0 rsp=%h", to, r, {1'b0, 1'b0, 16'h0055, 3'b000});
    end
  endtask

  task automatic test_illegal();
    rsp_t r;
    bit   to;
    do_single(0, 4'hF, 16'h0005, 16'h0006, r, to);
    n_checks++;
    if ({to, r} !== {1'b0, 1'b0, 1'b1, 16'h0000, 3'b000}) begin
      n_fail++; $display("FAIL illegal_f: got to=%b rsp=%h expected to=0 rsp=%h", to, r, {1'b0, 1'b1, 16'h0000, 3'b000});
    end
    do_single(1, 4'd0, 16'h0001, 16'h0001, r, to);
    n_checks++;
    if ({to, r} !== {1'b0, 1'b1, 1'b0, 16'h0002, 3'b000}) begin
      n_fail++; $display("FAIL illegal_next: got to=%b rsp=%h expected to=0 rsp=%h", to, r, {1'b1, 1'b0, 16'h0002, 3'b000});
    end
    do_single(1, 4'd7, 16'h8000, 16'h8000, r, to);
    n_checks++;
    if ({to, r} !== {1'b0, 1'b1, 1'b1, 16'h0000, 3'b000}) begin
      n_fail++; $display("FAIL illegal_7: got to=%b rsp=%h expected to=0 rsp=%h", to, r, {1'b1, 1'b1, 16'h0000, 3'b000});
    end
  endtask

  task automatic test_reset_midop();
    // Requester 0 alone wins, leaving the pointer favouring requester 1.
    @(negedge CLK);
    bus.RspRdy = 1'b0;
    bus.ReqVal0 = 1'b1; bus.ReqCode0 = 4'd0; bus.ReqOpA0 = 16'h0002; bus.ReqOpB0 = 16'h0002;
    @(negedge CLK);
    bus.ReqVal1 = 1'b1; bus.ReqCode1 = 4'd0; bus.ReqOpA1 = 16'h0009; bus.ReqOpB1 = 16'h0001;
    bus.ReqOpA0 = 16'h0001; bus.ReqOpB0 = 16'h0001;
    #1;
    n_checks++;
    if ({bus.ReqRdy1, bus.ReqRdy0} !== 2'b00) begin
      n_fail++; $display("FAIL midop_exec_rdy: got %b expected 00", {bus.ReqRdy1, bus.ReqRdy0});
    end
    #1 RST = 1'b0;
    #1;
    n_checks++;
    if ({bus.RspVal, bus.ReqRdy1, bus.ReqRdy0, bus.AluOpA} !== 19'h0) begin
      n_fail++; $display("FAIL midop_async: got %h expected 0", {bus.RspVal, bus.ReqRdy1, bus.ReqRdy0, bus.AluOpA});
    end
    @(negedge CLK);
    RST = 1'b1;
    #1;
    n_checks++;
    if ({bus.ReqRdy1, bus.ReqRdy0} !== 2'b01) begin
      n_fail++; $display("FAIL midop_ptr: got %b expected 01", {bus.ReqRdy1, bus.ReqRdy0});
    end
    @(negedge CLK);
    bus.ReqVal0 = 1'b0; bus.ReqVal1 = 1'b0;
    @(negedge CLK); #1;
    n_checks++;
    if ({bus.RspVal, bus.RspRes, bus.RspId} !== {1'b1, 16'h0002, 1'b0}) begin
      n_fail++; $display("FAIL midop_after: got val=%b res=%h id=%b expected 1 0002 0", bus.RspVal, bus.RspRes, bus.RspId);
    end
    // Reset while a response is held: RspVal must drop before any clock edge.
    #1 RST = 1'b0;
    #1;
    n_checks++;
    if (bus.RspVal !== 1'b0) begin
      n_fail++; $display("FAIL midop_resp_async: got RspVal=%b expected 0", bus.RspVal);
    end
    @(negedge CLK);
    RST = 1'b1;
    bus.RspRdy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK); #1;
      n_checks++;
      if (bus.RspVal !== 1'b0) begin
        n_fail++; $display("FAIL midop_replay: cycle %0d got RspVal=%b expected 0", k, bus.RspVal);
      end
    end
    bus.RspRdy = 1'b0;
  endtask

  function automatic logic [3:0] rand_code();
    int r;
    r = $urandom_range(0, 9);
    if (r <= 6) return 4'(r);
    if (r == 7) return 4'd7;
    if (r == 8) return 4'hF;
    return 4'h9;
  endfunction

  function automatic logic [15:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'h7FFF;
      2: return 16'h8000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic test_random(input int cycles);
    rsp_t q[$];
    rsp_t o;
    rsp_t e;
    logic mptr;
    logic w;
    int   age;
    int   n;
    logic g0p, g1p;
    apply_reset();
    mptr = 1'b0; age = 0; g0p = 1'b0; g1p = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge CLK);
      if (g0p || !bus.ReqVal0) begin
        bus.ReqVal0 = 1'($urandom_range(0, 1));
        bus.ReqCode0 = rand_code(); bus.ReqOpA0 = rand_op(); bus.ReqOpB0 = rand_op();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.ReqVal0 = 1'b0;
      end
      if (g1p || !bus.ReqVal1) begin
        bus.ReqVal1 = 1'($urandom_range(0, 1));
        bus.ReqCode1 = rand_code(); bus.ReqOpA1 = rand_op(); bus.ReqOpB1 = rand_op();
      end else if ($urandom_range(0, 7) == 0) begin
        bus.ReqVal1 = 1'b0;
      end
      bus.RspRdy = ($urandom_range(0, 2) != 0);
      #1;
      if (q.size() > 0) age++;
      if (bus.RspVal) begin
        o = {bus.RspId, bus.RspErr, bus.RspRes, bus.RspFlags};
        n_checks++;
        if (q.size() == 0) begin
          n_fail++; $display("FAIL rnd_spurious: got response %h expected none", o);
        end else begin
          if (o !== q[0]) begin
            n_fail++; $display("FAIL rnd_rsp: got %h expected %h", o, q[0]);
          end
          if (bus.RspRdy) void'(q.pop_front());
        end
      end else if (q.size() > 0) begin
        n_checks++;
        if (age >= 2) begin
          n_fail++; $display("FAIL rnd_latency: got no response after %0d cycles expected within 2", age);
        end
      end
      n_checks++;
      if (bus.ReqRdy0 && bus.ReqRdy1) begin
        n_fail++; $display("FAIL rnd_two_grants: got 11 expected at most one");
      end
      n_checks++;
      if ((bus.ReqRdy0 && !bus.ReqVal0) || (bus.ReqRdy1 && !bus.ReqVal1)) begin
        n_fail++; $display("FAIL rnd_rdy_no_val: got rdy=%b val=%b expected rdy only with val",
                           {bus.ReqRdy1, bus.ReqRdy0}, {bus.ReqVal1, bus.ReqVal0});
      end
      g0p = bus.ReqRdy0; g1p = bus.ReqRdy1;
      if (g0p || g1p) begin
        w = g1p;
        if (bus.ReqVal0 && bus.ReqVal1) begin
          n_checks++;
          if (w !== mptr) begin
            n_fail++; $display("FAIL rnd_fair: got winner %b expected %b", w, mptr);
          end
        end
        mptr = ~w;
        n_checks++;
        if (q.size() != 0) begin
          n_fail++; $display("FAIL rnd_overlap: got %0d in flight at accept expected 0", q.size());
        end
        e = w ? exp_rsp(1'b1, bus.ReqCode1, bus.ReqOpA1, bus.ReqOpB1)
              : exp_rsp(1'b0, bus.ReqCode0, bus.ReqOpA0, bus.ReqOpB0);
        q.push_back(e);
        age = 0;
      end
    end
    @(negedge CLK);
    idle_inputs();
    bus.RspRdy = 1'b1;
    n = 0;
    while (q.size() > 0 && n < 10) begin
      #1;
      if (bus.RspVal) begin
        o = {bus.RspId, bus.RspErr, bus.RspRes, bus.RspFlags};
        n_checks++;
        if (o !== q[0]) begin
          n_fail++; $display("FAIL rnd_drain_rsp: got %h expected %h", o, q[0]);
        end
        void'(q.pop_front());
      end
      @(negedge CLK);
      n++;
    end
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL rnd_drain: got %0d outstanding expected 0", q.size());
    end
    bus.RspRdy = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_overflow_bez();
    test_illegal();
    test_reset_midop();
    test_random(800);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
